cgra_multiport_scratchpad: RTL and testbench

//  Parametrised N-port word-addressed scratchpad that backs the CGRA mem_N_mem_unit interfaces.
//  - Generalises the fixed 5-port simulation RAM: port count, width, depth and read latency are configurable.
//  - Adds deterministic same-cycle write-collision priority and out-of-range detection.
//  - Adds a host port for preload/dump of N, input data and twiddle tables without hierarchical writes.

---
 rtl/cgra_multiport_scratchpad_pkg.sv | 13 +
 rtl/cgra_multiport_scratchpad_rd_pipe.sv | 22 ++
 rtl/cgra_multiport_scratchpad.sv | 105 ++++++++++
 tb/tb_cgra_multiport_scratchpad.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cgra_multiport_scratchpad_pkg.sv
// cgra_multiport_scratchpad_pkg: shared word type, default sizing and writer arbitration helper
package cgra_multiport_scratchpad_pkg;
  localparam int MAX_WR    = 9;
  localparam int DEF_DEPTH = 1024;
  localparam int WORD_AW   = $clog2(DEF_DEPTH);
  typedef logic [31:0]       word_t;
  typedef logic [MAX_WR-1:0] wr_vec_t;
  // lowest set bit wins: bit 0 is the host, bit p+1 is CGRA port p
  function automatic logic [3:0] prio_enc(input wr_vec_t req);
    prio_enc = 4'(MAX_WR);
    for (int i = MAX_WR - 1; i >= 0; i--) if (req[i]) prio_enc = 4'(i);
  endfunction
endpackage

// File: rtl/cgra_multiport_scratchpad_rd_pipe.sv
// cgra_ram_rd_pipe: fixed-length read delay line carrying {flag, data}
module cgra_ram_rd_pipe
  import cgra_multiport_scratchpad_pkg::*;
#(
  parameter int W   = 33,
  parameter int LAT = 1
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_stage [LAT];
  // shift the sampled word through LAT registers, no bubbles
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) for (int i = 0; i < LAT; i++) r_stage[i] <= '0;
    else begin
      r_stage[0] <= i_d;
      for (int i = 1; i < LAT; i++) r_stage[i] <= r_stage[i-1];
    end
  assign o_q = r_stage[LAT-1];
endmodule

// File: rtl/cgra_multiport_scratchpad.sv
// cgra_multiport_scratchpad: N-port word scratchpad with host port, write priority and collision tracking
module cgra_multiport_scratchpad
  import cgra_multiport_scratchpad_pkg::*;
#(
  parameter int NUM_PORTS    = 5,
  parameter int DATA_W       = $bits(word_t),
  parameter int ADDR_W       = 32,
  parameter int DEPTH        = 2 ** WORD_AW,
  parameter int ADDR_LSB     = 2,
  parameter int READ_LATENCY = 1
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic [NUM_PORTS*ADDR_W-1:0] addr,
  input  logic [NUM_PORTS*DATA_W-1:0] data_in,
  input  logic [NUM_PORTS-1:0]        w_rq,
  output logic [NUM_PORTS*DATA_W-1:0] data_out,
  output logic [NUM_PORTS-1:0]        oor_err,
  output logic                        collision,
  output logic [15:0]                 collision_cnt,
  input  logic                        host_en,
  input  logic                        host_we,
  input  logic [$clog2(DEPTH)-1:0]    host_addr,
  input  logic [DATA_W-1:0]           host_wdata,
  output logic [DATA_W-1:0]           host_rdata
);
  localparam int NW  = NUM_PORTS + 1;
  localparam int HAW = $clog2(DEPTH);
  logic [DATA_W-1:0]    r_mem [DEPTH];
  logic [ADDR_W-1:0]    w_word [NUM_PORTS];
  logic [HAW-1:0]       w_idx [NW];
  logic [DATA_W-1:0]    w_wdata [NW];
  logic [NUM_PORTS-1:0] w_oor;
  logic [NW-1:0]        w_en;
  logic [NW-1:0]        w_win;
  wr_vec_t              w_hit;
  logic                 w_coll;
  logic                 r_coll;
  logic [15:0]          r_cnt;
  logic [DATA_W-1:0]    r_host_hold;
  logic [DATA_W:0]      w_hq;
  // decode writers: slot 0 is the host, slot p+1 is port p; out-of-range ports never write
  always_comb begin
    w_idx[0]   = host_addr;
    w_wdata[0] = host_wdata;
    w_en[0]    = host_en && host_we;
    for (int p = 0; p < NUM_PORTS; p++) begin
      w_word[p]    = addr[p*ADDR_W +: ADDR_W] >> ADDR_LSB;
      w_oor[p]     = |(w_word[p] >> HAW);
      w_idx[p+1]   = w_word[p][HAW-1:0];
      w_wdata[p+1] = data_in[p*DATA_W +: DATA_W];
      w_en[p+1]    = w_rq[p] && !w_oor[p];
    end
  end
  // per-word arbitration: each writer commits only if it is the top-priority hit on its word
  always_comb begin
    w_coll = 1'b0;
    w_hit  = '0;
    w_win  = '0;
    for (int i = 0; i < NW; i++) begin
      w_hit = '0;
      for (int j = 0; j < NW; j++) w_hit[j] = w_en[j] && w_idx[j] == w_idx[i];
      w_win[i] = w_en[i] && prio_enc(w_hit) == 4'(i);
      w_coll   = w_coll || (w_en[i] && (w_hit & ~(wr_vec_t'(1) << i)) != '0);
    end
  end
  // commit winning writes; an edge seen while reset is held drops its writes
  always_ff @(posedge clock)
    if (reset_n)
      for (int i = 0; i < NW; i++)
        if (w_win[i]) r_mem[w_idx[i]] <= w_wdata[i];
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic [DATA_W:0] w_q;
    cgra_ram_rd_pipe #(.W(DATA_W + 1), .LAT(READ_LATENCY)) u_pipe (
      .clock   (clock),
      .reset_n (reset_n),
      .i_d     ({w_oor[p], w_oor[p] ? {DATA_W{1'b0}} : r_mem[w_idx[p+1]]}),
      .o_q     (w_q)
    );
    assign data_out[p*DATA_W +: DATA_W] = w_q[DATA_W-1:0];
    assign oor_err[p]                   = w_q[DATA_W];
  end
  cgra_ram_rd_pipe #(.W(DATA_W + 1), .LAT(READ_LATENCY)) u_host_pipe (
    .clock   (clock),
    .reset_n (reset_n),
    .i_d     ({host_en && !host_we, r_mem[host_addr]}),
    .o_q     (w_hq)
  );
  // keep the last completed host read visible between host reads
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) r_host_hold <= '0;
    else if (w_hq[DATA_W]) r_host_hold <= w_hq[DATA_W-1:0];
  assign host_rdata = w_hq[DATA_W] ? w_hq[DATA_W-1:0] : r_host_hold;
  // registered collision pulse and saturating cycle counter
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      r_coll <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_coll <= w_coll;
      r_cnt  <= r_cnt + 16'(w_coll && !(&r_cnt));
    end
  assign collision     = r_coll;
  assign collision_cnt = r_cnt;
endmodule

// File: tb/tb_cgra_multiport_scratchpad.sv
// tb_cgra_multiport_scratchpad: directed tables, corner sequences, config sweep and random model check
module tb_cgra_multiport_scratchpad;
  localparam int NP = 5, DW = 32, AW = 32, DEPTH = 1024, LAT = 2;
  logic clock = 1'b0;
  logic reset_n;
  logic [NP*AW-1:0] addr;
  logic [NP*DW-1:0] data_in, data_out;
  logic [NP-1:0] w_rq, oor_err;
  logic collision;
  logic [15:0] collision_cnt;
  logic host_en, host_we;
  logic [9:0] host_addr;
  logic [DW-1:0] host_wdata, host_rdata;
  int total = 0, bad = 0;
  always #5 clock = ~clock;
  cgra_multiport_scratchpad #(.NUM_PORTS(NP), .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .ADDR_LSB(2), .READ_LATENCY(LAT)) dut (
    .clock(clock), .reset_n(reset_n), .addr(addr), .data_in(data_in), .w_rq(w_rq),
    .data_out(data_out), .oor_err(oor_err), .collision(collision), .collision_cnt(collision_cnt),
    .host_en(host_en), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata), .host_rdata(host_rdata)
  );
  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  function automatic logic [DW-1:0] dout(input int p);
    return data_out[p*DW +: DW];
  endfunction
  task automatic host_write(input logic [9:0] a, input logic [DW-1:0] d);
    host_en = 1; host_we = 1; host_addr = a; host_wdata = d;
    tick();
    host_en = 0; host_we = 0;
  endtask
  task automatic host_read(input logic [9:0] a, input logic [DW-1:0] exp, input string nm);
    host_en = 1; host_we = 0; host_addr = a;
    tick();
    host_en = 0;
    repeat (LAT - 1) tick();
    check(nm, host_rdata, exp);
  endtask
  // configuration sweep: single-port/latency-1 and eight-port/latency-3 instances
  for (genvar g = 0; g < 2; g++) begin : g_sw
    localparam int P = g ? 8 : 1;
    localparam int L = g ? 3 : 1;
    localparam int Q = P - 1;
    logic s_rst, s_hen, s_hwe, s_hcoll, done = 1'b0;
    logic [P*32-1:0] s_addr, s_din, s_dout;
    logic [P-1:0] s_wrq, s_oor;
    logic [15:0] s_cnt;
    logic [9:0] s_haddr;
    logic [31:0] s_hwd, s_hrd;
    cgra_multiport_scratchpad #(.NUM_PORTS(P), .READ_LATENCY(L)) u_sw (
      .clock(clock), .reset_n(s_rst), .addr(s_addr), .data_in(s_din), .w_rq(s_wrq),
      .data_out(s_dout), .oor_err(s_oor), .collision(s_hcoll), .collision_cnt(s_cnt),
      .host_en(s_hen), .host_we(s_hwe), .host_addr(s_haddr), .host_wdata(s_hwd), .host_rdata(s_hrd)
    );
    task automatic stk(input int n);
      repeat (n) begin
        @(posedge clock);
        #1;
      end
    endtask
    initial begin
      s_rst = 0; s_addr = '0; s_din = '0; s_wrq = '0; s_hen = 0; s_hwe = 0; s_haddr = '0; s_hwd = '0;
      stk(2);
      s_rst = 1;
      s_hen = 1; s_hwe = 1; s_haddr = 10'd0; s_hwd = 32'd16;
      stk(1);
      s_haddr = 10'h280; s_hwd = 32'h7FFF0000;
      stk(1);
      s_haddr = 10'd7; s_hwd = 32'h77;
      for (int p = 0; p < P; p++) begin
        s_addr[p*32 +: 32] = 32'h1C;
        s_din[p*32 +: 32] = 32'(p + 1);
      end
      s_wrq = '1;
      stk(1);
      s_hen = 0; s_hwe = 0;
      for (int p = 0; p < P; p++) begin
        s_addr[p*32 +: 32] = 32'h24;
        s_din[p*32 +: 32] = 32'h900 + 32'(p);
      end
      stk(1);
      s_wrq = '0; s_addr = '0;
      stk(L);
      s_addr[Q*32 +: 32] = 32'hA00;
      stk(1);
      s_addr[Q*32 +: 32] = 32'h0;
      for (int k = 1; k <= L + 1; k++) begin
        check($sformatf("sw%0d_lat_k%0d", g, k), s_dout[Q*32 +: 32], k == L ? 32'h7FFF0000 : 32'd16);
        if (k <= L) stk(1);
      end
      s_addr[Q*32 +: 32] = 32'h1C;
      stk(L);
      check($sformatf("sw%0d_host_prio", g), s_dout[Q*32 +: 32], 32'h77);
      s_addr[Q*32 +: 32] = 32'h24;
      stk(L);
      check($sformatf("sw%0d_port_prio", g), s_dout[Q*32 +: 32], 32'h900);
      check($sformatf("sw%0d_coll_cnt", g), s_cnt, P > 1 ? 16'd2 : 16'd1);
      done = 1'b1;
    end
  end
  typedef struct {logic [31:0] a; logic wr; logic [31:0] d; logic [31:0] ed; logic eo;} vec_t;
  typedef struct packed {logic [NP-1:0][DW-1:0] d; logic [NP-1:0] o; logic hv; logic [DW-1:0] hd;} exp_t;
  vec_t tbl [12];
  exp_t q [$];
  logic [DW-1:0] ref_mem [16];
  initial begin
    exp_t e, e2;
    int wc [16];
    int pw [NP];
    bit po [NP];
    bit cm, hk, oo;
    int mcnt, wd;
    logic [DW-1:0] hold;
    tbl[0]  = '{32'h080, 1'b1, 32'hA1, 32'h0, 1'b0};
    tbl[1]  = '{32'h080, 1'b0, 32'h0, 32'hA1, 1'b0};
    tbl[2]  = '{32'h080, 1'b1, 32'hB2, 32'hA1, 1'b0};
    tbl[3]  = '{32'h080, 1'b0, 32'h0, 32'hB2, 1'b0};
    tbl[4]  = '{32'h1000, 1'b1, 32'hCC, 32'h0, 1'b1};
    tbl[5]  = '{32'h000, 1'b0, 32'h0, 32'd16, 1'b0};
    tbl[6]  = '{32'h1000, 1'b0, 32'h0, 32'h0, 1'b1};
    tbl[7]  = '{32'hFFC, 1'b1, 32'hD4, 32'h0, 1'b0};
    tbl[8]  = '{32'hFFF, 1'b0, 32'h0, 32'hD4, 1'b0};
    tbl[9]  = '{32'h1003, 1'b0, 32'h0, 32'h0, 1'b1};
    tbl[10] = '{32'hFFFFFFFC, 1'b0, 32'h0, 32'h0, 1'b1};
    tbl[11] = '{32'h082, 1'b0, 32'h0, 32'hB2, 1'b0};
    reset_n = 0; addr = '0; data_in = '0; w_rq = '0; host_en = 0; host_we = 0; host_addr = '0; host_wdata = '0;
    tick(); tick();
    check("rst_dout", data_out, '0);
    check("rst_oor", oor_err, '0);
    check("rst_hrd", host_rdata, '0);
    check("rst_coll", collision, 1'b0);
    check("rst_cnt", collision_cnt, 16'd0);
    reset_n = 1;
    for (int i = 0; i < 64; i++) host_write(10'(i), '0);
    host_write(10'd1023, '0);
    host_write(10'd0, 32'd16);
    host_write(10'h280, 32'h7FFF0000);
    repeat (LAT) tick();
    addr[2*AW +: AW] = 32'hA00;
    tick();
    addr[2*AW +: AW] = 32'h0;
    for (int k = 1; k <= LAT + 1; k++) begin
      check($sformatf("preload_lat_k%0d", k), dout(2), k == LAT ? 32'h7FFF0000 : 32'd16);
      if (k <= LAT) tick();
    end
    addr[1*AW +: AW] = 32'h40; data_in[1*DW +: DW] = 32'd1;
    addr[3*AW +: AW] = 32'h40; data_in[3*DW +: DW] = 32'd3;
    addr[4*AW +: AW] = 32'h40; data_in[4*DW +: DW] = 32'd4;
    w_rq = 5'b11010;
    tick();
    w_rq = '0; addr = '0;
    check("coll_pulse", collision, 1'b1);
    check("coll_cnt1", collision_cnt, 16'd1);
    tick();
    check("coll_drop", collision, 1'b0);
    check("coll_cnt_hold", collision_cnt, 16'd1);
    host_read(10'd16, 32'd1, "coll_word");
    host_en = 1; host_we = 1; host_addr = 10'd5; host_wdata = 32'h55;
    addr[0 +: AW] = 32'h14; data_in[0 +: DW] = 32'h66; w_rq[0] = 1;
    tick();
    host_en = 0; host_we = 0; w_rq = '0;
    check("host_prio_cnt", collision_cnt, 16'd2);
    host_read(10'd5, 32'h55, "host_prio_word");
    addr[0 +: AW] = 32'h10; data_in[0 +: DW] = 32'hDEADBEEF; w_rq[0] = 1;
    addr[1*AW +: AW] = 32'h10;
    tick();
    w_rq = '0;
    repeat (LAT - 1) tick();
    check("rbw_cross_old", dout(1), 32'h0);
    check("rbw_same_old", dout(0), 32'h0);
    tick();
    check("rbw_cross_new", dout(1), 32'hDEADBEEF);
    addr = '0;
    addr[3*AW +: AW] = 32'hA00;
    for (int i = 0; i < 12; i++) begin
      addr[0 +: AW] = tbl[i].a; w_rq[0] = tbl[i].wr; data_in[0 +: DW] = tbl[i].d;
      tick();
      w_rq = '0;
      repeat (LAT - 1) tick();
      check($sformatf("tbl%0d_data", i), dout(0), tbl[i].ed);
      check($sformatf("tbl%0d_oor", i), oor_err[0], tbl[i].eo);
      check($sformatf("tbl%0d_p3", i), {oor_err[3], dout(3)}, {1'b0, 32'h7FFF0000});
    end
    addr = '0;
    host_en = 1; host_we = 0; host_addr = 10'h280; addr[0 +: AW] = 32'hA00;
    tick();
    host_en = 0;
    #3 reset_n = 0;
    #1;
    check("amid_dout", data_out, '0);
    check("amid_oor", oor_err, '0);
    check("amid_hrd", host_rdata, '0);
    check("amid_coll", collision, 1'b0);
    check("amid_cnt", collision_cnt, 16'd0);
    addr[2*AW +: AW] = 32'hA00; data_in[2*DW +: DW] = 32'h12345678; w_rq[2] = 1;
    tick();
    reset_n = 1; w_rq = '0; addr = '0;
    host_read(10'h280, 32'h7FFF0000, "post_rst_word");
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = $urandom;
      host_write(10'(i), ref_mem[i]);
    end
    mcnt = 0; hk = 0; hold = '0;
    for (int c = 0; c < 400; c++) begin
      foreach (wc[i]) wc[i] = 0;
      for (int p = 0; p < NP; p++) begin
        oo = $urandom_range(0, 7) == 0;
        wd = oo ? 1024 + int'($urandom_range(0, 15)) : int'($urandom_range(0, 15));
        addr[p*AW +: AW] = 32'(wd << 2) | 32'($urandom_range(0, 3));
        w_rq[p] = 1'($urandom_range(0, 1));
        data_in[p*DW +: DW] = $urandom;
        e.d[p] = oo ? '0 : ref_mem[wd % 16];
        e.o[p] = oo;
        pw[p] = wd % 16; po[p] = oo;
        if (w_rq[p] && !oo) wc[wd]++;
      end
      host_en = 1'($urandom_range(0, 1)); host_we = 1'($urandom_range(0, 1));
      host_addr = 10'($urandom_range(0, 15)); host_wdata = $urandom;
      e.hv = host_en && !host_we;
      e.hd = ref_mem[host_addr[3:0]];
      if (host_en && host_we) wc[host_addr[3:0]]++;
      cm = 0;
      foreach (wc[i]) if (wc[i] >= 2) cm = 1;
      if (cm) mcnt++;
      for (int p = NP - 1; p >= 0; p--) if (w_rq[p] && !po[p]) ref_mem[pw[p]] = data_in[p*DW +: DW];
      if (host_en && host_we) ref_mem[host_addr[3:0]] = host_wdata;
      tick();
      q.push_back(e);
      check("rnd_coll", collision, cm);
      check("rnd_cnt", collision_cnt, 16'(mcnt));
      if (q.size() == LAT) begin
        e2 = q.pop_front();
        check("rnd_dout", data_out, e2.d);
        check("rnd_oor", oor_err, e2.o);
        if (e2.hv) begin
          hk = 1;
          hold = e2.hd;
        end
        if (hk) check("rnd_hrd", host_rdata, hold);
      end
    end
    host_en = 0; w_rq = '0;
    for (int k = 0; k < 3000 && !(g_sw[0].done && g_sw[1].done); k++) tick();
    check("sweep_done", {g_sw[0].done, g_sw[1].done}, 2'b11);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
